// File: rtl/rv32_pkg.sv
// Shared RV32I constants: branch funct3 encodings and the default datapath width.
package rv32_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decoder: funct3 plus ALU flags from rs1 - rs2.
// Carry is NOT borrow, so cf=1 means rs1 >= rs2 unsigned.
module branch_cond
    import rv32_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       cf_i,
    input  logic       zf_i,
    input  logic       sf_i,
    input  logic       vf_i,
    output logic       taken_o,
    output logic       illegal_o
);

    // Decode the condition; the two unused encodings flag illegal and never take.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = zf_i;
            F3_BNE:  taken_o = !zf_i;
            F3_BLT:  taken_o = (sf_i != vf_i);
            F3_BGE:  taken_o = (sf_i == vf_i);
            F3_BLTU: taken_o = !cf_i;
            F3_BGEU: taken_o = cf_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage between EX and PC-select. One-cycle registered
// result with an output register backed by a one-entry skid buffer.
module branch_resolve_unit
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            cf,
    input  logic            zf,
    input  logic            sf,
    input  logic            vf,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            misaligned,
    output logic            illegal
);

    typedef struct packed {
        logic            taken;
        logic            misaligned;
        logic            illegal;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
    } result_t;

    localparam result_t RESET_RES = '{
        taken:      1'b0,
        misaligned: 1'b0,
        illegal:    1'b0,
        target:     RESET_PC,
        link:       RESET_PC
    };

    logic            cond_taken;
    logic            cond_illegal;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] jalr_sum;
    result_t         res_new;

    result_t out_q, out_d;
    result_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept;
    logic    out_free;

    branch_cond u_branch_cond (
        .funct3_i  (funct3),
        .cf_i      (cf),
        .zf_i      (zf),
        .sf_i      (sf),
        .vf_i      (vf),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    // Resolve the incoming request; priority is JALR, then JAL, then branch.
    always_comb begin
        pc_plus_imm = pc + imm;
        pc_plus_4   = pc + XLEN'(4);
        jalr_sum    = rs1 + imm;

        res_new.taken   = 1'b0;
        res_new.illegal = 1'b0;
        res_new.target  = pc_plus_4;
        res_new.link    = pc_plus_4;
        if (is_jalr) begin
            res_new.taken  = 1'b1;
            res_new.target = jalr_sum & ~XLEN'(1);
        end else if (is_jal) begin
            res_new.taken  = 1'b1;
            res_new.target = pc_plus_imm;
        end else if (is_branch) begin
            res_new.taken   = cond_taken;
            res_new.illegal = cond_illegal;
            res_new.target  = pc_plus_imm;
        end
        // No C extension, so any taken target off a 4-byte boundary faults.
        res_new.misaligned = res_new.taken & res_new.target[1];
    end

    // in_ready depends only on skid occupancy, keeping out_ready off the input path.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign out_free = !out_valid_q || out_ready;

    // Next state of the output and skid registers.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Skid holds the older entry; in_ready was low so no accept here.
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = res_new;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = res_new;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= RESET_RES;
            skid_q       <= RESET_RES;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign taken      = out_q.taken;
    assign target     = out_q.target;
    assign link       = out_q.link;
    assign misaligned = out_q.misaligned;
    assign illegal    = out_q.illegal;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU flag interface: takes the cf/zf/sf/vf flags the ALU produces on a subtract, plus branch/jump decode fields, and resolves taken/not-taken, target PC, link address and misalignment.
- Sits between EX and PC-select/fetch redirect in the pipelined RV32I core.
- Registered, one-cycle latency, valid/ready on both sides, with a one-entry skid buffer so upstream may issue back-to-back under backpressure.

Parameters:
- XLEN, 32, datapath width for pc/imm/rs1/target/link.
- RESET_PC, 32'h0000_0000, value driven on target/link while out_valid=0 after reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- is_branch  in  1  conditional branch (B-type).
- is_jal  in  1  JAL.
- is_jalr  in  1  JALR.
- funct3  in  3  branch condition select.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  JALR base register value.
- cf, zf, sf, vf  in  1 each  ALU flags from rs1 - rs2 (carry = NOT borrow).
- flush  in  1  kill all held entries.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  redirect required.
- target  out  XLEN  redirect PC.
- link  out  XLEN  pc+4 for rd writeback.
- misaligned  out  1  taken AND target[1]=1; no C extension.
- illegal  out  1  is_branch with funct3 010 or 011.

Behaviour:
- Reset (sync, rst=1 at posedge): out_valid=0, skid empty, in_ready=1, taken=0, misaligned=0, illegal=0, target=link=RESET_PC. Reset overrides flush and in-flight entries, and any result held mid-stall is discarded.
- Accept: in_valid && in_ready at a posedge.
- Latency: result on out_valid exactly 1 cycle after accept when the output register is free.
- Condition codes (is_branch):
  - 000 BEQ: zf
  - 001 BNE: !zf
  - 100 BLT: sf != vf
  - 101 BGE: sf == vf
  - 110 BLTU: !cf
  - 111 BGEU: cf
  - 010/011: taken=0, illegal=1
- is_jal or is_jalr: taken=1 regardless of flags.
- None of is_branch/is_jal/is_jalr set: taken=0, target=pc+4.
- Priority when more than one type is set: is_jalr > is_jal > is_branch.
- Target: branch/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared. All sums modulo 2^XLEN; wrap at 32'hFFFF_FFFC+8 gives 32'h4.
- Link = pc+4, modulo 2^XLEN.
- misaligned: asserted only when taken=1.
- Output register plus skid register:
  - Output stalled (out_valid && !out_ready) and a new accept arrives: the entry goes to skid, and in_ready=0 from the next cycle.
  - When the output is consumed, skid moves to output in the same edge and in_ready returns to 1.
- in_ready is a registered function of skid state only, with no combinational path from out_ready.
- Outputs hold stable while out_valid && !out_ready.
- flush=1 at a posedge: output and skid invalidate. An accept in the same cycle is dropped. in_ready=1 next cycle.
- Ordering: strictly FIFO, with no reordering or duplication.

Decomposition:
- Shared package rv32_pkg holds the funct3 branch constants (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the XLEN default.
- Sub-module branch_cond, a combinational funct3+flags → taken/illegal decoder, reused by the single-cycle core.
- The skid/pipeline register stays in the top module.

Test Plan:
- BEQ, zf=1, pc=0x100, imm=0x20 → next cycle out_valid=1, taken=1, target=0x120, link=0x104. BNE with the same flags → taken=0.
- BLT with sf=1, vf=0 → taken. BLTU with cf=1 → not taken. BGEU with cf=1 → taken. funct3=010 → illegal=1, taken=0.
- JALR, rs1=0x1003, imm=4 → target=0x1006, taken=1, misaligned=1. rs1=0x1001, imm=3 → target=0x1004, misaligned=0.
- out_ready=0 for 3 cycles while 3 back-to-back requests (pc 0x10/0x20/0x30) are offered → first two accepted, in_ready=0, third held upstream. When out_ready=1, results drain in order 0x10, 0x20, 0x30 with no loss.
- flush asserted with output and skid both full → out_valid=0 next cycle, in_ready=1, nothing emitted. Then rst=1 mid-stall → all outputs return to their reset values on the next posedge.
- JAL, pc=0xFFFF_FFFC, imm=8 → target=0x0000_0004, link=0x0000_0000.
